// File: rtl/code_patch_pkg.sv
// Shared types and default sizing for the code patch controller.
package code_patch_pkg;

  localparam int N_ENTRY = 3;
  localparam int ADDR_W  = 13;
  localparam int DATA_W  = 8;
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/code_patch_cam.sv
// Address compare across all patch entries; lowest matching index wins.
module code_patch_cam
  import code_patch_pkg::*;
#(
  parameter int N_ENTRY = code_patch_pkg::N_ENTRY,
  parameter int IDX_W   = 2
) (
  input  entry_t            entries_i [N_ENTRY],
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Scan high to low so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = N_ENTRY - 1; k >= 0; k--) begin
      if (entries_i[k].valid && (entries_i[k].addr == addr_i)) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/code_patch_ctrl.sv
// Code patch controller: entry table, config write port, armed fetch matching,
// sequential clear and a saturating hit counter.
module code_patch_ctrl
  import code_patch_pkg::*;
#(
  parameter int N_ENTRY = code_patch_pkg::N_ENTRY,
  parameter int ADDR_W  = code_patch_pkg::ADDR_W,
  parameter int DATA_W  = code_patch_pkg::DATA_W,
  localparam int ENTRY_W = 1 + ADDR_W + DATA_W,
  localparam int IDX_W   = (N_ENTRY > 1) ? $clog2(N_ENTRY) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_pat_gen_i,
  input  logic               clr_i,
  // Config write: accepted on any cycle where cfg_valid_i & cfg_ready_o;
  // cfg_ready_o may depend combinationally on si_read_i (reads win).
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  input  logic [IDX_W-1:0]   cfg_idx_i,
  input  logic [ENTRY_W-1:0] cfg_data_i,
  input  logic               si_read_i,
  input  logic [ADDR_W-1:0]  si_addr_i,
  output logic               hit_o,
  output logic [IDX_W-1:0]   hit_idx_o,
  output logic [DATA_W-1:0]  patch_data_o,
  output logic               nopg_o,
  output logic               busy_o,
  output logic               err_o,
  output logic [7:0]         hit_cnt_o,
  output state_e             state_o
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_cnt_q, clr_cnt_d;
  entry_t             entry_q [N_ENTRY];
  logic               hit_q;
  logic [IDX_W-1:0]   hit_idx_q;
  logic [DATA_W-1:0]  data_q;
  logic               err_q;
  logic [7:0]         cnt_q;

  logic               wr_acc, wr_bad;
  logic               cam_hit, rd_hit;
  logic [IDX_W-1:0]   cam_idx;
  logic [DATA_W-1:0]  cam_data;
  entry_t             wr_entry;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next-state logic; CLEAR walks one entry per cycle and ignores clr_i.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_i)              state_d = ST_CLEAR;
        else if (cfg_pat_gen_i) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (clr_i)               state_d = ST_CLEAR;
        else if (!cfg_pat_gen_i) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + IDX_W'(1);
        if (clr_cnt_q == IDX_W'(N_ENTRY - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    cfg_ready_o = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      ST_IDLE:  cfg_ready_o = 1'b1;
      ST_ARMED: cfg_ready_o = ~si_read_i;
      ST_CLEAR: busy_o      = 1'b1;
      default:  cfg_ready_o = 1'b0;
    endcase
  end

  assign state_o  = state_q;
  assign wr_acc   = cfg_valid_i & cfg_ready_o;
  assign wr_bad   = int'(cfg_idx_i) >= N_ENTRY;
  assign wr_entry = entry_t'(cfg_data_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < N_ENTRY; k++) entry_q[k] <= '0;
    end else begin
      for (int k = 0; k < N_ENTRY; k++) begin
        if ((state_q == ST_CLEAR) && (clr_cnt_q == IDX_W'(k)))
          entry_q[k] <= '0;
        else if (wr_acc && !wr_bad && (cfg_idx_i == IDX_W'(k)))
          entry_q[k] <= wr_entry;
      end
    end
  end

  // Matching sees the registered table, i.e. before any same-edge write.
  code_patch_cam #(
    .N_ENTRY (N_ENTRY),
    .IDX_W   (IDX_W)
  ) u_cam (
    .entries_i (entry_q),
    .addr_i    (si_addr_i),
    .hit_o     (cam_hit),
    .idx_o     (cam_idx)
  );

  assign rd_hit = (state_q == ST_ARMED) & si_read_i & cam_hit;

  always_comb begin
    cam_data = '0;
    for (int k = 0; k < N_ENTRY; k++) begin
      if (cam_idx == IDX_W'(k)) cam_data = entry_q[k].data;
    end
  end

  always_comb begin
    nopg_o = 1'b1;
    for (int k = 0; k < N_ENTRY; k++) begin
      if (entry_q[k].valid) nopg_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_q     <= 1'b0;
      hit_idx_q <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      hit_q     <= rd_hit;
      hit_idx_q <= rd_hit ? cam_idx : '0;
      data_q    <= rd_hit ? cam_data : '0;
      err_q     <= wr_acc & wr_bad;
      if ((state_q != ST_CLEAR) && (state_d == ST_CLEAR))
        cnt_q <= '0;
      else if (rd_hit)
        cnt_q <= sat_inc8(cnt_q);
    end
  end

  assign hit_o        = hit_q;
  assign hit_idx_o    = hit_idx_q;
  assign patch_data_o = data_q;
  assign err_o        = err_q;
  assign hit_cnt_o    = cnt_q;

endmodule

// File: doc/code_patch_ctrl.md
CODE_PATCH_CTRL -- requirements
Module: code_patch_ctrl

Interface
REQ-001 The block SHALL have parameter N_ENTRY, default 3, meaning number of patch entries.
REQ-002 The block SHALL have parameter ADDR_W, default 13, meaning patched address width.
REQ-003 The block SHALL have parameter DATA_W, default 8, meaning replacement data width; entry width = 1+ADDR_W+DATA_W = 22.
REQ-004 The block SHALL have one clock and one reset; the reset SHALL be asynchronous and active-high; ports are listed below.
REQ-005 clk_i  input  1  clock, all state updates on its rising edge.
REQ-006 rst_i  input  1  asynchronous, active-high reset.
REQ-007 cfg_pat_gen_i  input  1  patch enable; 1 = arm matching.
REQ-008 clr_i  input  1  single-cycle pulse requesting a clear of all entries.
REQ-009 cfg_valid_i / cfg_ready_o  input / output  1 / 1  config write handshake.
REQ-010 cfg_idx_i  input  2  entry index for the config write.
REQ-011 cfg_data_i  input  22  entry value: [21] valid, [20:8] address, [7:0] data.
REQ-012 si_read_i  input  1  fetch read strobe.
REQ-013 si_addr_i  input  13  fetch address.
REQ-014 hit_o  output  1  registered patch hit.
REQ-015 hit_idx_o  output  2  index of the hitting entry.
REQ-016 patch_data_o  output  8  replacement data of the hitting entry.
REQ-017 nopg_o  output  1  1 when no entry is valid.
REQ-018 busy_o  output  1  1 while in CLEAR.
REQ-019 err_o  output  1  one-cycle pulse on an accepted write with cfg_idx_i >= N_ENTRY.
REQ-020 hit_cnt_o  output  8  saturating count of hits.

Function
REQ-021 The FSM SHALL have states IDLE, ARMED and CLEAR.
REQ-022 From IDLE, the FSM SHALL go to CLEAR when clr_i=1; otherwise it SHALL go to ARMED when cfg_pat_gen_i=1. clr_i has priority.
REQ-023 From ARMED, the FSM SHALL go to CLEAR when clr_i=1; otherwise it SHALL go to IDLE when cfg_pat_gen_i=0.
REQ-024 CLEAR SHALL zero entry k in CLEAR cycle k (k = 0..N_ENTRY-1), then go to IDLE; clr_i SHALL be ignored while in CLEAR.
REQ-025 cfg_ready_o SHALL be 1 in IDLE, ~si_read_i in ARMED, and 0 in CLEAR. Reads have priority over config writes.
REQ-026 A write SHALL be accepted on the cycle where cfg_valid_i & cfg_ready_o; the entry SHALL be updated on that edge.
REQ-027 On an accepted write with cfg_idx_i >= N_ENTRY, no entry SHALL change and err_o SHALL pulse on the next cycle.
REQ-028 When state = ARMED and si_read_i = 1 at cycle N, hit_o at N+1 SHALL be 1 if any valid entry address equals si_addr_i.
REQ-029 If several entries match, the lowest index SHALL win.
REQ-030 When hit_o = 0, hit_idx_o and patch_data_o SHALL be 0.
REQ-031 Matching SHALL use the table value as it was before any same-cycle write.
REQ-032 If cfg_pat_gen_i drops, no hit SHALL be produced for reads in the cycle after the drop or later.
REQ-033 nopg_o SHALL be combinational: the NOR of all entry valid bits.
REQ-034 hit_cnt_o SHALL increment on each hit_o = 1, saturate at 255, and clear on entry to CLEAR.

Reset
REQ-035 While rst_i = 1: state = IDLE, all entries = 0, hit_o = 0, hit_idx_o = 0, patch_data_o = 0, err_o = 0, hit_cnt_o = 0, busy_o = 0, nopg_o = 1, cfg_ready_o = 1.
REQ-036 Reset asserted mid-CLEAR or mid-write SHALL abort the operation; no partial state SHALL survive.

Structure
REQ-037 Package code_patch_pkg SHALL hold N_ENTRY, ADDR_W, DATA_W, the packed entry struct typedef (valid/addr/data) and the state enum.
REQ-038 Sub-module code_patch_cam SHALL hold the combinational address compare and the lowest-index priority encode (outputs hit and idx).

Verification
REQ-039 Reset, then write idx0 = {1,0x0A5,0x3C}, arm, read 0x0A5 -> next cycle hit_o=1, hit_idx_o=0, patch_data_o=0x3C, nopg_o=0.
REQ-040 Entries 1 and 2 both at address 0x100, read 0x100 -> hit_idx_o=1.
REQ-041 Armed, si_read_i=1 with cfg_valid_i=1 -> cfg_ready_o=0 and no write until si_read_i=0; write with idx=3 -> err_o pulses once, table unchanged.
REQ-042 Three entries valid, clr_i pulse -> busy_o=1 for 3 cycles, then nopg_o=1, hit_cnt_o=0, state IDLE.
REQ-043 300 consecutive hitting reads -> hit_cnt_o=255; rst_i asserted in the 2nd CLEAR cycle -> all outputs at reset values immediately.
